ram_port_arbiter: RTL and testbench

RAM_PORT_ARBITER -- requirements
Module: ram_port_arbiter

---
 rtl/ram_port_arbiter.sv | 98 +++++++++
 tb/tb_ram_port_arbiter.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/ram_port_arbiter.sv
// Two-requester arbiter in front of a single RAM-like port. Grants are combinational; a
// requester may hold the port for up to QUANTUM consecutive grants while the other waits.
module ram_port_arbiter #(
  parameter int unsigned ADDR_WIDTH = 64,
  parameter int unsigned DATA_WIDTH = 64,
  parameter int unsigned QUANTUM    = 4
) (
  input  logic                           clk_i,
  input  logic                           rst_ni,
  input  logic [1:0]                     req_i,
  input  logic [1:0]                     we_i,
  input  logic [1:0][ADDR_WIDTH-1:0]     addr_i,
  input  logic [1:0][DATA_WIDTH-1:0]     wdata_i,
  input  logic [1:0][DATA_WIDTH/8-1:0]   be_i,
  output logic [1:0]                     gnt_o,
  output logic [1:0]                     rvalid_o,
  output logic [DATA_WIDTH-1:0]          rdata_o,
  output logic                           mem_en_o,
  output logic                           mem_we_o,
  output logic [ADDR_WIDTH-1:0]          mem_addr_o,
  output logic [DATA_WIDTH-1:0]          mem_wdata_o,
  output logic [DATA_WIDTH/8-1:0]        mem_be_o,
  input  logic [DATA_WIDTH-1:0]          mem_rdata_i
);

  localparam logic [3:0] Quantum = 4'(QUANTUM);

  logic       last_q, last_d;
  logic [3:0] cnt_q, cnt_d;
  logic [1:0] rvalid_q, rvalid_d;
  logic       gnt_any;
  logic       gnt_idx;

  // Hold the current owner until its tenure reaches the quantum, then let the other in.
  always_comb begin
    gnt_any = 1'b0;
    gnt_idx = last_q;
    if (req_i[last_q] && (cnt_q != 4'd0) && (cnt_q < Quantum)) begin
      gnt_any = 1'b1;
      gnt_idx = last_q;
    end else if (req_i[!last_q]) begin
      gnt_any = 1'b1;
      gnt_idx = !last_q;
    end else if (req_i[last_q]) begin
      gnt_any = 1'b1;
      gnt_idx = last_q;
    end
  end

  always_comb begin
    gnt_o       = 2'b00;
    mem_en_o    = 1'b0;
    mem_we_o    = 1'b0;
    mem_addr_o  = '0;
    mem_wdata_o = '0;
    mem_be_o    = '0;
    if (gnt_any) begin
      gnt_o       = gnt_idx ? 2'b10 : 2'b01;
      mem_en_o    = 1'b1;
      mem_we_o    = we_i[gnt_idx];
      mem_addr_o  = addr_i[gnt_idx];
      mem_wdata_o = wdata_i[gnt_idx];
      mem_be_o    = be_i[gnt_idx];
    end
  end

  always_comb begin
    last_d   = last_q;
    cnt_d    = 4'd0;
    rvalid_d = 2'b00;
    if (gnt_any) begin
      last_d = gnt_idx;
      if ((gnt_idx == last_q) && (cnt_q != 4'd0)) begin
        cnt_d = (cnt_q >= Quantum) ? Quantum : cnt_q + 4'd1;
      end else begin
        cnt_d = 4'd1;
      end
      rvalid_d = we_i[gnt_idx] ? 2'b00 : gnt_o;
    end
  end

  // Reset owner is requester 1 so requester 0 wins the first contended cycle.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      last_q   <= 1'b1;
      cnt_q    <= 4'd0;
      rvalid_q <= 2'b00;
    end else begin
      last_q   <= last_d;
      cnt_q    <= cnt_d;
      rvalid_q <= rvalid_d;
    end
  end

  assign rvalid_o = rvalid_q;
  assign rdata_o  = mem_rdata_i;

endmodule

// File: tb/tb_ram_port_arbiter.sv
// Randomized bench for ram_port_arbiter; a tenure-based reference model checks a QUANTUM=4 and a
// QUANTUM=1 instance every cycle, with directed sequences anchored to fixed expected values.
module tb_ram_port_arbiter;

  logic              clk = 1'b0;
  logic              rst_ni;
  logic [1:0]        req_i, we_i;
  logic [1:0][63:0]  addr_i, wdata_i;
  logic [1:0][7:0]   be_i;
  logic [63:0]       mem_rdata_i;

  logic [1:0]  gnt_o, rvalid_o;
  logic [63:0] rdata_o;
  logic        mem_en_o, mem_we_o;
  logic [63:0] mem_addr_o, mem_wdata_o;
  logic [7:0]  mem_be_o;

  logic [1:0]  gnt1, rvalid1;
  logic [63:0] rdata1;
  logic        mem_en1, mem_we1;
  logic [63:0] mem_addr1, mem_wdata1;
  logic [7:0]  mem_be1;

  int n_cmp = 0;
  int n_err = 0;

  // Model state per instance: 0 -> QUANTUM=4, 1 -> QUANTUM=1.
  int         m_q[2] = '{4, 1};
  logic       m_last[2];
  int         m_streak[2];
  logic [1:0] m_rv[2];

  logic        use_nx = 1'b0;
  logic [63:0] nx_addr, nx_wdata;
  logic [7:0]  nx_be;

  always #5 clk = ~clk;

  ram_port_arbiter #(.ADDR_WIDTH(64), .DATA_WIDTH(64), .QUANTUM(4)) dut (
    .clk_i(clk), .rst_ni(rst_ni), .req_i(req_i), .we_i(we_i), .addr_i(addr_i),
    .wdata_i(wdata_i), .be_i(be_i), .gnt_o(gnt_o), .rvalid_o(rvalid_o), .rdata_o(rdata_o),
    .mem_en_o(mem_en_o), .mem_we_o(mem_we_o), .mem_addr_o(mem_addr_o),
    .mem_wdata_o(mem_wdata_o), .mem_be_o(mem_be_o), .mem_rdata_i(mem_rdata_i)
  );

  ram_port_arbiter #(.ADDR_WIDTH(64), .DATA_WIDTH(64), .QUANTUM(1)) dut_q1 (
    .clk_i(clk), .rst_ni(rst_ni), .req_i(req_i), .we_i(we_i), .addr_i(addr_i),
    .wdata_i(wdata_i), .be_i(be_i), .gnt_o(gnt1), .rvalid_o(rvalid1), .rdata_o(rdata1),
    .mem_en_o(mem_en1), .mem_we_o(mem_we1), .mem_addr_o(mem_addr1),
    .mem_wdata_o(mem_wdata1), .mem_be_o(mem_be1), .mem_rdata_i(mem_rdata_i)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic logic [1:0] onehot(input logic idx);
    return idx ? 2'b10 : 2'b01;
  endfunction

  function automatic logic [1:0] model_gnt(input int q, input logic last, input int streak,
                                           input logic [1:0] req);
    if (req[last] && streak > 0 && streak < q) return onehot(last);
    if (req[!last]) return onehot(!last);
    if (req[last]) return onehot(last);
    return 2'b00;
  endfunction

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      m_last[k]   = 1'b1;
      m_streak[k] = 0;
      m_rv[k]     = 2'b00;
    end
  endtask

  // One clock: drive at negedge, check combinational and registered outputs, advance model.
  task automatic cycle(input logic [1:0] req, input logic [1:0] we, input logic rst);
    logic [1:0] eg[2];
    logic       g;
    @(negedge clk);
    rst_ni = rst;
    req_i  = req;
    we_i   = we;
    for (int k = 0; k < 2; k++) begin
      addr_i[k]  = {$urandom(), $urandom()};
      wdata_i[k] = {$urandom(), $urandom()};
      be_i[k]    = 8'($urandom());
    end
    if (use_nx) begin
      addr_i[1]  = nx_addr;
      wdata_i[1] = nx_wdata;
      be_i[1]    = nx_be;
    end
    mem_rdata_i = {$urandom(), $urandom()};
    if (!rst) model_reset();
    #1;
    for (int k = 0; k < 2; k++) eg[k] = model_gnt(m_q[k], m_last[k], m_streak[k], req);
    check("gnt_q4", 64'(gnt_o), 64'(eg[0]));
    check("gnt_q1", 64'(gnt1), 64'(eg[1]));
    check("rvalid_q4", 64'(rvalid_o), 64'(m_rv[0]));
    check("rvalid_q1", 64'(rvalid1), 64'(m_rv[1]));
    check("mem_en", 64'(mem_en_o), 64'(eg[0] != 2'b00));
    if (eg[0] != 2'b00) begin
      g = eg[0][1];
      check("mem_we", 64'(mem_we_o), 64'(we[g]));
      check("mem_addr", mem_addr_o, addr_i[g]);
      check("mem_wdata", mem_wdata_o, wdata_i[g]);
      check("mem_be", 64'(mem_be_o), 64'(be_i[g]));
    end else begin
      check("mem_idle", {mem_addr_o ^ mem_wdata_o} | 64'({mem_be_o, mem_we_o}), 64'd0);
    end
    if (m_rv[0] != 2'b00) check("rdata", rdata_o, mem_rdata_i);
    if (rst) begin
      for (int k = 0; k < 2; k++) begin
        if (eg[k] != 2'b00) begin
          g = eg[k][1];
          m_streak[k] = (g == m_last[k] && m_streak[k] != 0) ? m_streak[k] + 1 : 1;
          m_last[k]   = g;
          m_rv[k]     = we[g] ? 2'b00 : eg[k];
        end else begin
          m_streak[k] = 0;
          m_rv[k]     = 2'b00;
        end
      end
    end
  endtask

  task automatic do_reset();
    cycle(2'b00, 2'b00, 1'b0);
    cycle(2'b00, 2'b00, 1'b0);
  endtask

  logic [1:0] exp37[10];
  logic [1:0] prev;

  initial begin
    rst_ni = 1'b0; req_i = '0; we_i = '0; addr_i = '0; wdata_i = '0; be_i = '0;
    mem_rdata_i = '0;
    nx_addr = '0; nx_wdata = '0; nx_be = '0;
    model_reset();

    // Reset state: outputs depend only on req, requester 0 wins contention.
    do_reset();
    check("rst_gnt_idle", 64'(gnt_o), 64'd0);
    check("rst_rvalid", 64'(rvalid_o), 64'd0);
    cycle(2'b11, 2'b00, 1'b0);
    check("rst_gnt_contended", 64'(gnt_o), 64'd1);

    // Both reading for 10 cycles with quantum 4; quantum 1 instance alternates.
    exp37 = '{2'b01, 2'b01, 2'b01, 2'b01, 2'b10, 2'b10, 2'b10, 2'b10, 2'b01, 2'b01};
    do_reset();
    prev = 2'b00;
    for (int i = 0; i < 10; i++) begin
      cycle(2'b11, 2'b00, 1'b1);
      check("seq37_gnt", 64'(gnt_o), 64'(exp37[i]));
      check("seq37_rvalid", 64'(rvalid_o), 64'(prev));
      check("seq42_gnt", 64'(gnt1), (i % 2 == 0) ? 64'd1 : 64'd2);
      prev = exp37[i];
    end

    // Sole requester saturates, then yields when the other arrives.
    do_reset();
    for (int i = 0; i < 6; i++) begin
      cycle(2'b01, 2'b00, 1'b1);
      check("seq38_solo", 64'(gnt_o), 64'd1);
    end
    cycle(2'b11, 2'b00, 1'b1);
    check("seq38_rotate", 64'(gnt_o), 64'd2);

    // An idle cycle ends the tenure, so the other requester goes first.
    do_reset();
    cycle(2'b01, 2'b00, 1'b1);
    cycle(2'b01, 2'b00, 1'b1);
    cycle(2'b00, 2'b00, 1'b1);
    cycle(2'b11, 2'b00, 1'b1);
    check("seq39_gnt", 64'(gnt_o), 64'd2);

    // Directed write from requester 1.
    do_reset();
    use_nx = 1'b1; nx_addr = 64'h40; nx_wdata = 64'hDEAD; nx_be = 8'hFF;
    cycle(2'b10, 2'b10, 1'b1);
    check("seq40_en", 64'(mem_en_o), 64'd1);
    check("seq40_we", 64'(mem_we_o), 64'd1);
    check("seq40_addr", mem_addr_o, 64'h40);
    check("seq40_wdata", mem_wdata_o, 64'hDEAD);
    check("seq40_be", 64'(mem_be_o), 64'hFF);
    use_nx = 1'b0;
    cycle(2'b00, 2'b00, 1'b1);
    check("seq40_rvalid", 64'(rvalid_o), 64'd0);

    // Reset in the cycle after an accepted read discards the response.
    do_reset();
    cycle(2'b11, 2'b00, 1'b1);
    cycle(2'b10, 2'b00, 1'b1);
    cycle(2'b01, 2'b00, 1'b1);
    check("seq41_accept", 64'(gnt_o), 64'd1);
    cycle(2'b00, 2'b00, 1'b0);
    check("seq41_rvalid_rst", 64'(rvalid_o), 64'd0);
    cycle(2'b00, 2'b00, 1'b1);
    check("seq41_rvalid_after", 64'(rvalid_o), 64'd0);
    cycle(2'b11, 2'b00, 1'b1);
    check("seq41_gnt", 64'(gnt_o), 64'd1);

    // Random traffic with occasional resets.
    do_reset();
    for (int i = 0; i < 3000; i++) begin
      cycle(2'($urandom()), 2'($urandom()), ($urandom_range(0, 99) != 0));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
